sdram_cmd_responder: RTL and testbench

SDRAM_CMD_RESPONDER -- requirements
Module: sdram_cmd_responder

---
 rtl/sdram_ctrl_pkg.sv | 41 ++++
 rtl/sdram_rsp_rd_pipe.sv | 42 ++++
 rtl/sdram_cmd_responder.sv | 187 ++++++++++++++++++
 tb/tb_sdram_cmd_responder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/sdram_ctrl_pkg.sv
// Shared types for the SDRAM command responder.
// Command encodings, init FSM states and error codes.
package sdram_ctrl_pkg;

  typedef enum logic [2:0] {
    CMD_LMR   = 3'b000,
    CMD_REF   = 3'b001,
    CMD_PRE   = 3'b010,
    CMD_ACT   = 3'b011,
    CMD_WRITE = 3'b100,
    CMD_READ  = 3'b101,
    CMD_BST   = 3'b110,
    CMD_NOP   = 3'b111
  } sdram_cmd_t;

  typedef enum logic [1:0] {
    INIT_PRE,
    INIT_REF,
    INIT_LMR,
    READY
  } sdram_rsp_init_t;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_CLOSED    = 3'd1,
    ERR_ACT_OPEN  = 3'd2,
    ERR_REF_OPEN  = 3'd3,
    ERR_NOT_READY = 3'd4,
    ERR_LMR       = 3'd5,
    ERR_CONTEND   = 3'd6
  } sdram_rsp_err_t;

  localparam int NUM_BANKS = 4;

  // Only CL 2/3 with burst length 1 is modelled.
  function automatic logic lmr_legal(input logic [12:0] a);
    return ((a[6:4] == 3'd2) || (a[6:4] == 3'd3))
        && (a[2:0] == 3'b000);
  endfunction

endpackage

// File: rtl/sdram_rsp_rd_pipe.sv
// Read-data delay line: CAS latency 2 or 3, one word per cycle.
// Output data is zero whenever no word is being driven.
module sdram_rsp_rd_pipe
  import sdram_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cl3,
  input  logic        in_vld,
  input  logic [15:0] in_data,
  output logic        pending,
  output logic        out_vld,
  output logic [15:0] out_data
);

  logic [2:0]       s_vld;
  logic [2:0][15:0] s_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_vld    <= '0;
      s_data   <= '0;
      out_vld  <= 1'b0;
      out_data <= '0;
    end else begin
      s_vld    <= {s_vld[1:0], in_vld};
      s_data   <= {s_data[1:0], in_data};
      if (cl3) begin
        out_vld  <= s_vld[2];
        out_data <= s_vld[2] ? s_data[2] : '0;
      end else begin
        out_vld  <= s_vld[1];
        out_data <= s_vld[1] ? s_data[1] : '0;
      end
    end
  end

  // Words still in flight that will reach the bus later.
  assign pending = s_vld[0] | s_vld[1]
                 | (cl3 & s_vld[2]);

endmodule

// File: rtl/sdram_cmd_responder.sv
// SDRAM device-side responder model with init tracking.
// Define SDRAM_RSP_CHECK_EN to enable protocol error checks.
module sdram_cmd_responder
  import sdram_ctrl_pkg::*;
#(
  parameter int ROW_IDX_W = 4,
  parameter int COL_IDX_W = 4
) (
  input  logic        Clock,
  input  logic        Rst,
  input  logic        DRAM_CKE,
  input  logic        DRAM_CS_N,
  input  logic        DRAM_RAS_N,
  input  logic        DRAM_CAS_N,
  input  logic        DRAM_WE_N,
  input  logic [1:0]  DRAM_BA,
  input  logic [12:0] DRAM_ADDR,
  input  logic        DRAM_DQML,
  input  logic        DRAM_DQMH,
  input  logic [15:0] DqIn,
  output logic [15:0] DqOut,
  output logic        DqOe,
  output logic        InitDone,
  output logic        ProtoErr,
  output logic [2:0]  ErrCode
);

  localparam int IDX_W = 2 + ROW_IDX_W + COL_IDX_W;
  localparam int DEPTH = 1 << IDX_W;

  sdram_cmd_t      cmd;
  sdram_rsp_init_t state, state_nxt;
  sdram_rsp_err_t  err;
  logic            ref_cnt, ref_cnt_nxt;
  logic            ready, lmr_ok, a10;
  logic            cl3;

  logic [NUM_BANKS-1:0]       bank_open;
  logic [NUM_BANKS-1:0][12:0] open_row;

  logic             cur_open, rw_ok;
  logic             do_rd, do_wr, rd_pending;
  logic [IDX_W-1:0] idx;
  logic [15:0]      mem [DEPTH];
  logic [15:0]      rd_word, rd_data;

  always_comb begin
    cmd = CMD_NOP;
    if (DRAM_CKE && !DRAM_CS_N)
      cmd = sdram_cmd_t'({DRAM_RAS_N,
                          DRAM_CAS_N,
                          DRAM_WE_N});
  end

  assign a10    = DRAM_ADDR[10];
  assign lmr_ok = lmr_legal(DRAM_ADDR);
  assign ready  = (state == READY);

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      state   <= INIT_PRE;
      ref_cnt <= 1'b0;
    end else begin
      state   <= state_nxt;
      ref_cnt <= ref_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    ref_cnt_nxt = ref_cnt;
    unique case (state)
      INIT_PRE:
        if (cmd == CMD_PRE && a10)
          state_nxt = INIT_REF;
      INIT_REF:
        if (cmd == CMD_REF) begin
          ref_cnt_nxt = ~ref_cnt;
          if (ref_cnt) state_nxt = INIT_LMR;
        end
      INIT_LMR:
        if (cmd == CMD_LMR && lmr_ok)
          state_nxt = READY;
      READY: ;
    endcase
  end

  assign cur_open = bank_open[DRAM_BA];
  assign idx = {DRAM_BA,
                open_row[DRAM_BA][ROW_IDX_W-1:0],
                DRAM_ADDR[COL_IDX_W-1:0]};

`ifdef SDRAM_RSP_CHECK_EN
  always_comb begin
    err = ERR_NONE;
    case (cmd)
      CMD_ACT:
        if (!ready)        err = ERR_NOT_READY;
        else if (cur_open) err = ERR_ACT_OPEN;
      CMD_READ:
        if (!ready)         err = ERR_NOT_READY;
        else if (!cur_open) err = ERR_CLOSED;
      CMD_WRITE:
        if (!ready)          err = ERR_NOT_READY;
        else if (!cur_open)  err = ERR_CLOSED;
        else if (rd_pending) err = ERR_CONTEND;
      CMD_REF:
        if (|bank_open) err = ERR_REF_OPEN;
      CMD_LMR:
        if (!lmr_ok) err = ERR_LMR;
      default: ;
    endcase
  end

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      ProtoErr <= 1'b0;
      ErrCode  <= 3'd0;
    end else begin
      ProtoErr <= (err != ERR_NONE);
      if (err != ERR_NONE) ErrCode <= err;
    end
  end
`else
  assign err      = ERR_NONE;
  assign ProtoErr = 1'b0;
  assign ErrCode  = 3'd0;
`endif

  // A contended write still lands; other errors block access.
  assign rw_ok = cur_open
              && (err == ERR_NONE || err == ERR_CONTEND);
  assign do_rd = (cmd == CMD_READ)  && rw_ok;
  assign do_wr = (cmd == CMD_WRITE) && rw_ok;

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      bank_open <= '0;
      open_row  <= '0;
      cl3       <= 1'b0;
    end else begin
      case (cmd)
        CMD_ACT: begin
          bank_open[DRAM_BA] <= 1'b1;
          open_row[DRAM_BA]  <= DRAM_ADDR;
        end
        CMD_PRE:
          if (a10) bank_open <= '0;
          else     bank_open[DRAM_BA] <= 1'b0;
        CMD_READ, CMD_WRITE:
          if (rw_ok && a10) bank_open[DRAM_BA] <= 1'b0;
        CMD_LMR:
          if (lmr_ok) cl3 <= DRAM_ADDR[4];
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (do_wr) begin
      if (!DRAM_DQML) mem[idx][7:0]  <= DqIn[7:0];
      if (!DRAM_DQMH) mem[idx][15:8] <= DqIn[15:8];
    end
  end

  assign rd_word = mem[idx];
  assign rd_data = {DRAM_DQMH ? 8'h00 : rd_word[15:8],
                    DRAM_DQML ? 8'h00 : rd_word[7:0]};

  sdram_rsp_rd_pipe u_rd_pipe (
    .clk      (Clock),
    .rst      (Rst),
    .cl3      (cl3),
    .in_vld   (do_rd),
    .in_data  (rd_data),
    .pending  (rd_pending),
    .out_vld  (DqOe),
    .out_data (DqOut)
  );

  assign InitDone = ready;

  // Row bits above the index width are tracked but not addressed.
  logic unused_ok;
  assign unused_ok = ^{open_row, rd_pending};

endmodule

// File: tb/tb_sdram_cmd_responder.sv
// Directed bench for sdram_cmd_responder.
// Error expectations follow SDRAM_RSP_CHECK_EN.
module tb_sdram_cmd_responder;
  import sdram_ctrl_pkg::*;

`ifdef SDRAM_RSP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cke, cs_n, ras_n, cas_n, we_n;
  logic [1:0]  ba;
  logic [12:0] addr;
  logic        dqml, dqmh;
  logic [15:0] dq_in, dq_out;
  logic        dq_oe, init_done, proto_err;
  logic [2:0]  err_code;

  int n_cmp = 0;
  int n_bad = 0;
  int cl    = 2;

  always #5 clk = ~clk;

  sdram_cmd_responder dut (
    .Clock      (clk),
    .Rst        (rst),
    .DRAM_CKE   (cke),
    .DRAM_CS_N  (cs_n),
    .DRAM_RAS_N (ras_n),
    .DRAM_CAS_N (cas_n),
    .DRAM_WE_N  (we_n),
    .DRAM_BA    (ba),
    .DRAM_ADDR  (addr),
    .DRAM_DQML  (dqml),
    .DRAM_DQMH  (dqmh),
    .DqIn       (dq_in),
    .DqOut      (dq_out),
    .DqOe       (dq_oe),
    .InitDone   (init_done),
    .ProtoErr   (proto_err),
    .ErrCode    (err_code)
  );

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic issue(input sdram_cmd_t c,
                       input logic [1:0] b,
                       input logic [12:0] a,
                       input logic [1:0] dqm,
                       input logic [15:0] d);
    @(negedge clk);
    cke = 1'b1;
    cs_n = 1'b0;
    {ras_n, cas_n, we_n} = c;
    ba = b;
    addr = a;
    {dqmh, dqml} = dqm;
    dq_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    issue(CMD_NOP, 2'd0, 13'd0, 2'b00, 16'h0);
  endtask

  task automatic rd_expect(input string tag,
                           input logic [1:0] b,
                           input logic [12:0] a,
                           input logic [1:0] dqm,
                           input logic [15:0] exp);
    issue(CMD_READ, b, a, dqm, 16'h0);
    for (int k = 1; k <= cl; k++) begin
      nop();
      check({tag, "_oe"}, 16'(dq_oe), 16'(k == cl));
    end
    check({tag, "_data"}, dq_out, exp);
  endtask

  initial begin
    rst = 1'b1;
    cke = 1'b0; cs_n = 1'b1;
    {ras_n, cas_n, we_n} = 3'b111;
    ba = '0; addr = '0;
    dqml = 1'b0; dqmh = 1'b0; dq_in = '0;
    repeat (3) nop();
    check("rst_oe",   16'(dq_oe),     16'd0);
    check("rst_dq",   dq_out,         16'h0);
    check("rst_init", 16'(init_done), 16'd0);
    check("rst_perr", 16'(proto_err), 16'd0);
    check("rst_ecode", 16'(err_code), 16'd0);
    @(negedge clk);
    rst = 1'b0;

    // init sequence
    issue(CMD_PRE, 2'd0, 13'h400, 2'b00, 16'h0);
    check("init_pre", 16'(init_done), 16'd0);
    issue(CMD_REF, 2'd0, 13'h0, 2'b00, 16'h0);
    issue(CMD_REF, 2'd0, 13'h0, 2'b00, 16'h0);
    check("init_ref", 16'(init_done), 16'd0);
    issue(CMD_LMR, 2'd0, 13'h020, 2'b00, 16'h0);
    check("init_done", 16'(init_done), 16'd1);
    check("init_perr", 16'(proto_err), 16'd0);

    // write then CL2 read, exact window
    issue(CMD_ACT, 2'd0, 13'd5, 2'b00, 16'h0);
    issue(CMD_WRITE, 2'd0, 13'd3, 2'b00, 16'hA5C3);
    rd_expect("rd_cl2", 2'd0, 13'd3, 2'b00, 16'hA5C3);
    nop();
    check("rd_cl2_drop", 16'(dq_oe), 16'd0);
    check("rd_cl2_perr", 16'(proto_err), 16'd0);
    rd_expect("rd_dqml", 2'd0, 13'd3, 2'b01, 16'hA500);

    // byte mask on write
    issue(CMD_WRITE, 2'd0, 13'd7, 2'b00, 16'h1234);
    issue(CMD_WRITE, 2'd0, 13'd7, 2'b10, 16'hFFFF);
    rd_expect("wr_dqmh", 2'd0, 13'd7, 2'b00, 16'h12FF);

    // CL3 back-to-back reads
    issue(CMD_LMR, 2'd0, 13'h030, 2'b00, 16'h0);
    cl = 3;
    for (int i = 0; i < 4; i++)
      issue(CMD_WRITE, 2'd0, 13'(i), 2'b00, 16'(i));
    for (int i = 0; i < 8; i++) begin
      if (i < 4) issue(CMD_READ, 2'd0, 13'(i), 2'b00, 16'h0);
      else nop();
      check($sformatf("b2b_oe%0d", i), 16'(dq_oe),
            16'(i >= 3 && i <= 6));
      check($sformatf("b2b_dq%0d", i), dq_out,
            (i >= 3 && i <= 6) ? 16'(i - 3) : 16'h0);
    end

    // write while a read is in flight
    issue(CMD_READ, 2'd0, 13'd1, 2'b00, 16'h0);
    issue(CMD_WRITE, 2'd0, 13'd9, 2'b00, 16'hBEEF);
    check("cont_perr", 16'(proto_err), 16'(CHK));
    check("cont_code", 16'(err_code), CHK ? 16'd6 : 16'd0);
    nop();
    check("cont_pulse", 16'(proto_err), 16'd0);
    nop();
    check("cont_oe", 16'(dq_oe), 16'd1);
    check("cont_dq", dq_out, 16'h0001);
    nop();
    rd_expect("cont_wr", 2'd0, 13'd9, 2'b00, 16'hBEEF);

    // read from a closed bank
    issue(CMD_READ, 2'd1, 13'd0, 2'b00, 16'h0);
    check("closed_perr", 16'(proto_err), 16'(CHK));
    check("closed_code", 16'(err_code), CHK ? 16'd1 : 16'd0);
    for (int k = 0; k < 4; k++) begin
      nop();
      check($sformatf("closed_oe%0d", k), 16'(dq_oe), 16'd0);
    end
    check("closed_pulse", 16'(proto_err), 16'd0);
    issue(CMD_REF, 2'd0, 13'h0, 2'b00, 16'h0);
    check("ref_open", 16'(err_code), CHK ? 16'd3 : 16'd0);
    issue(CMD_ACT, 2'd0, 13'd5, 2'b00, 16'h0);
    check("act_open", 16'(err_code), CHK ? 16'd2 : 16'd0);
    rd_expect("act_relatch", 2'd0, 13'd2, 2'b00, 16'h0002);

    // reset during an in-flight CL3 read
    issue(CMD_READ, 2'd0, 13'd2, 2'b00, 16'h0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      nop();
      check($sformatf("rstrd_oe%0d", k), 16'(dq_oe), 16'd0);
    end
    check("rstrd_init", 16'(init_done), 16'd0);
    check("rstrd_code", 16'(err_code), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    issue(CMD_ACT, 2'd0, 13'd5, 2'b00, 16'h0);
    check("early_perr", 16'(proto_err), 16'(CHK));
    check("early_code", 16'(err_code), CHK ? 16'd4 : 16'd0);
    for (int k = 0; k < 3; k++) begin
      nop();
      check($sformatf("post_oe%0d", k), 16'(dq_oe), 16'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
